// File: rtl/sensor_frame_streamer.sv
// Snapshots NUM_CHANNELS samples and streams each snapshot as one Avalon-ST packet:
// a header beat {A5, channel count, sequence number} followed by the packed payload.
module sensor_frame_streamer #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned PERIOD_WIDTH = 32
) (
  input  logic                                 CLOCK,
  input  logic                                 RESET,
  input  logic                                 SEND_PACKET,
  input  logic                                 PERIODIC_EN,
  input  logic [PERIOD_WIDTH-1:0]              PERIOD,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] SAMPLES,
  output logic [31:0]                          ST_DATA,
  output logic                                 ST_VALID,
  input  logic                                 ST_READY,
  output logic                                 ST_SOP,
  output logic                                 ST_EOP,
  output logic [1:0]                           ST_EMPTY,
  output logic                                 BUSY,
  output logic [15:0]                          SEQ_NUM,
  output logic [15:0]                          DROP_COUNT
);

  localparam int unsigned SAMPLES_W     = NUM_CHANNELS * SAMPLE_WIDTH;
  localparam int unsigned PAYLOAD_BYTES = SAMPLES_W / 8;
  localparam int unsigned PAYLOAD_BEATS = (PAYLOAD_BYTES + 3) / 4;
  localparam int unsigned TOTAL_W       = PAYLOAD_BEATS * 32;
  localparam int unsigned BEAT_W        = (PAYLOAD_BEATS > 1) ? $clog2(PAYLOAD_BEATS) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PAYLOAD_BEATS - 1);
  localparam logic [1:0]        EOP_EMPTY = 2'(4 * PAYLOAD_BEATS - PAYLOAD_BYTES);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HEADER  = 2'd1;
  localparam logic [1:0] PAYLOAD = 2'd2;

  logic [1:0]              state, state_n;
  logic [BEAT_W-1:0]       beat, beat_n;
  logic [SAMPLES_W-1:0]    shadow, shadow_n;
  logic [PERIOD_WIDTH-1:0] count, count_n;
  logic                    pending, pending_n;
  logic [15:0]             seq_n, drop_n;
  logic [TOTAL_W-1:0]      packed_n;
  logic [31:0]             data_n;
  logic                    eop_n;
  logic                    period_on, tick, trig, accept;

  // State, timer, counters and registered stream outputs
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      beat       <= '0;
      shadow     <= '0;
      count      <= '0;
      pending    <= 1'b0;
      SEQ_NUM    <= '0;
      DROP_COUNT <= '0;
      ST_DATA    <= '0;
      ST_VALID   <= 1'b0;
      ST_SOP     <= 1'b0;
      ST_EOP     <= 1'b0;
      ST_EMPTY   <= '0;
      BUSY       <= 1'b0;
    end else begin
      state      <= state_n;
      beat       <= beat_n;
      shadow     <= shadow_n;
      count      <= count_n;
      pending    <= pending_n;
      SEQ_NUM    <= seq_n;
      DROP_COUNT <= drop_n;
      ST_DATA    <= data_n;
      ST_VALID   <= (state_n != IDLE);
      ST_SOP     <= (state_n == HEADER);
      ST_EOP     <= eop_n;
      ST_EMPTY   <= eop_n ? EOP_EMPTY : 2'd0;
      BUSY       <= (state_n != IDLE);
    end
  end

  // Next-state, trigger queuing and next-beat formatting
  always_comb begin
    state_n   = state;
    beat_n    = beat;
    shadow_n  = shadow;
    pending_n = pending;
    seq_n     = SEQ_NUM;
    drop_n    = DROP_COUNT;
    packed_n  = '0;
    data_n    = '0;
    eop_n     = 1'b0;

    period_on = PERIODIC_EN && (PERIOD != '0);
    tick      = period_on && (count == PERIOD - PERIOD_WIDTH'(1));
    count_n   = (!period_on || tick) ? '0 : count + PERIOD_WIDTH'(1);
    trig      = SEND_PACKET | tick;
    accept    = ST_VALID & ST_READY;

    // A trigger during a frame queues one deep; further ones are dropped
    if ((state != IDLE) && trig) begin
      if (!pending) begin
        pending_n = 1'b1;
      end else if (DROP_COUNT != 16'hFFFF) begin
        drop_n = DROP_COUNT + 16'd1;
      end
    end

    case (state)
      IDLE: begin
        // A trigger queued on the final EOP cycle is served here
        if (trig || pending) begin
          shadow_n  = SAMPLES;
          pending_n = 1'b0;
          state_n   = HEADER;
        end
      end
      HEADER: begin
        if (accept) begin
          state_n = PAYLOAD;
          beat_n  = '0;
        end
      end
      PAYLOAD: begin
        if (accept) begin
          if (beat == LAST_BEAT) begin
            seq_n = SEQ_NUM + 16'd1;
            if (pending) begin
              pending_n = 1'b0;
              shadow_n  = SAMPLES;
              state_n   = HEADER;
            end else begin
              state_n = IDLE;
            end
          end else begin
            beat_n = beat + BEAT_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Channel 0 lands in the most significant bytes; trailing pad bytes stay 0
    for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
      packed_n[TOTAL_W-1-ch*SAMPLE_WIDTH -: SAMPLE_WIDTH] = shadow_n[ch*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    end

    if (state_n == HEADER) begin
      data_n = {8'hA5, 8'(NUM_CHANNELS), seq_n};
    end else if (state_n == PAYLOAD) begin
      for (int unsigned b = 0; b < PAYLOAD_BEATS; b++) begin
        if (beat_n == BEAT_W'(b)) begin
          data_n = packed_n[TOTAL_W-1-32*b -: 32];
        end
      end
      eop_n = (beat_n == LAST_BEAT);
    end
  end

endmodule

// File: tb/tb_sensor_frame_streamer.sv
// Scoreboard bench: a frame-level reference model pushes expected beats, a monitor pops on handshake.
module tb_sensor_frame_streamer;

  localparam int unsigned NC    = 5;
  localparam int unsigned SW    = 16;
  localparam int unsigned PW    = 16;
  localparam int unsigned PB    = NC * SW / 8;
  localparam int unsigned BEATS = (PB + 3) / 4;

  logic              CLOCK = 1'b0;
  logic              RESET = 1'b0;
  logic              SEND_PACKET = 1'b0;
  logic              PERIODIC_EN = 1'b0;
  logic [PW-1:0]     PERIOD = '0;
  logic [NC*SW-1:0]  SAMPLES = '0;
  logic              ST_READY = 1'b1;
  logic [31:0]       ST_DATA;
  logic              ST_VALID, ST_SOP, ST_EOP, BUSY;
  logic [1:0]        ST_EMPTY;
  logic [15:0]       SEQ_NUM, DROP_COUNT;

  always #5 CLOCK = ~CLOCK;

  sensor_frame_streamer #(
    .NUM_CHANNELS(NC), .SAMPLE_WIDTH(SW), .PERIOD_WIDTH(PW)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .SEND_PACKET(SEND_PACKET), .PERIODIC_EN(PERIODIC_EN),
    .PERIOD(PERIOD), .SAMPLES(SAMPLES), .ST_DATA(ST_DATA), .ST_VALID(ST_VALID),
    .ST_READY(ST_READY), .ST_SOP(ST_SOP), .ST_EOP(ST_EOP), .ST_EMPTY(ST_EMPTY),
    .BUSY(BUSY), .SEQ_NUM(SEQ_NUM), .DROP_COUNT(DROP_COUNT)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
  } beat_t;

  beat_t       exp_q[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model state: frame progress counted in beats left to accept
  bit          m_busy;
  int          m_left;
  bit          m_pend;
  int          m_drop;
  int          m_seq;
  logic [PW-1:0] m_cnt;

  function void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function void model_reset();
    m_busy = 0; m_left = 0; m_pend = 0; m_drop = 0; m_seq = 0; m_cnt = '0;
    exp_q.delete();
  endfunction

  // Expected beats of one frame, built byte by byte from the snapshot
  function void push_frame(input logic [NC*SW-1:0] s, input int seq);
    logic [7:0] bytes [BEATS*4];
    beat_t b;
    for (int i = 0; i < int'(BEATS*4); i++) bytes[i] = 8'h00;
    for (int i = 0; i < int'(PB); i++) begin
      int ch, j;
      ch = i / int'(SW/8);
      j  = i % int'(SW/8);
      bytes[i] = 8'(s >> (ch*int'(SW) + int'(SW) - 8*(j+1)));
    end
    b.data = {8'hA5, 8'(NC), 16'(seq)}; b.sop = 1'b1; b.eop = 1'b0; b.empty = 2'd0;
    exp_q.push_back(b);
    for (int k = 0; k < int'(BEATS); k++) begin
      b.data  = {bytes[4*k], bytes[4*k+1], bytes[4*k+2], bytes[4*k+3]};
      b.sop   = 1'b0;
      b.eop   = (k == int'(BEATS) - 1);
      b.empty = b.eop ? 2'(4*BEATS - PB) : 2'd0;
      exp_q.push_back(b);
    end
  endfunction

  // One clock of the reference model, using the inputs seen at this edge
  function void model_step();
    bit per_on, tick, trig, pend_old;
    per_on   = PERIODIC_EN && (PERIOD != '0);
    tick     = per_on && (m_cnt == PERIOD - PW'(1));
    m_cnt    = (!per_on || tick) ? '0 : m_cnt + PW'(1);
    trig     = SEND_PACKET | tick;
    pend_old = m_pend;
    if (!m_busy) begin
      if (trig || m_pend) begin
        m_pend = 0;
        push_frame(SAMPLES, m_seq);
        m_busy = 1;
        m_left = int'(BEATS) + 1;
      end
    end else begin
      if (trig) begin
        if (pend_old) m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
        else m_pend = 1;
      end
      if (ST_READY) begin
        m_left--;
        if (m_left == 0) begin
          m_seq = (m_seq + 1) & 16'hFFFF;
          if (pend_old) begin
            m_pend = 0;
            push_frame(SAMPLES, m_seq);
            m_left = int'(BEATS) + 1;
          end else begin
            m_busy = 0;
          end
        end
      end
    end
  endfunction

  task automatic step();
    @(posedge CLOCK);
    if (!RESET) model_step();
    #1;
  endtask

  task automatic set_reset(input bit v);
    RESET = v;
    if (v) model_reset();
  endtask

  // Monitor: checks outputs every falling edge and pops a beat on each handshake
  beat_t prev_beat;
  bit    prev_stall = 0;
  initial begin
    beat_t cur, e;
    forever begin
      @(negedge CLOCK);
      cur = '{data: ST_DATA, sop: ST_SOP, eop: ST_EOP, empty: ST_EMPTY};
      if (RESET) begin
        check("reset_outputs", 64'({ST_DATA, ST_VALID, ST_SOP, ST_EOP, ST_EMPTY, BUSY, SEQ_NUM, DROP_COUNT}), 64'd0);
        prev_stall = 0;
      end else begin
        check("valid", 64'(ST_VALID), 64'(m_busy));
        check("busy", 64'(BUSY), 64'(m_busy));
        check("seq_num", 64'(SEQ_NUM), 64'(m_seq));
        check("drop_count", 64'(DROP_COUNT), 64'(m_drop));
        if (prev_stall) check("stall_hold", 64'({ST_VALID, cur}), 64'({1'b1, prev_beat}));
        if (ST_VALID && ST_READY) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 64'(cur), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("beat", 64'(cur), 64'(e));
          end
        end
        prev_stall = ST_VALID && !ST_READY;
        prev_beat  = cur;
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic
  initial begin
    logic [NC*SW-1:0] base;
    model_reset();
    #1 set_reset(1);
    repeat (3) step();
    set_reset(0);
    base = {16'h9ABC, 16'h5678, 16'h1234, 16'hBEEF, 16'hDEAD};
    SAMPLES = base;
    repeat (2) step();

    // Single frame, full throughput
    SEND_PACKET = 1; step(); SEND_PACKET = 0;
    repeat (8) step();

    // Backpressure on the first payload beat while the live samples change
    SEND_PACKET = 1; step(); SEND_PACKET = 0;
    step();
    ST_READY = 0; SAMPLES = '0;
    repeat (3) step();
    ST_READY = 1;
    repeat (6) step();
    SAMPLES = base;

    // Three consecutive triggers: one frame, one queued, one dropped
    SEND_PACKET = 1; repeat (3) step(); SEND_PACKET = 0;
    repeat (14) step();

    // Periodic mode then disabled
    PERIOD = 16'd20; PERIODIC_EN = 1;
    repeat (65) step();
    PERIODIC_EN = 0;
    repeat (30) step();

    // Reset during a payload beat, then a fresh frame
    SEND_PACKET = 1; step(); SEND_PACKET = 0;
    repeat (2) step();
    set_reset(1);
    repeat (2) step();
    set_reset(0);
    step();
    SEND_PACKET = 1; step(); SEND_PACKET = 0;
    repeat (8) step();

    // PERIOD=1 fires every cycle; drops accumulate
    PERIOD = 16'd1; PERIODIC_EN = 1;
    repeat (30) step();
    PERIODIC_EN = 0;
    repeat (10) step();

    // Randomized traffic with backpressure, periodic changes and rare resets
    for (int i = 0; i < 3000; i++) begin
      SEND_PACKET = ($urandom_range(0, 9) == 0);
      ST_READY    = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < int'(NC); c++) SAMPLES[c*SW +: SW] = SW'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        PERIODIC_EN = $urandom_range(0, 1);
        PERIOD      = PW'($urandom_range(0, 40));
      end
      if ($urandom_range(0, 999) == 0) begin
        set_reset(1); step(); set_reset(0);
      end
      step();
    end

    // Drain and confirm every expected beat was delivered
    SEND_PACKET = 0; PERIODIC_EN = 0; ST_READY = 1;
    repeat (30) step();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
